// File: rtl/regfile_sched_pkg.sv
// Shared constants and types for the RegisterFile port scheduler.
// Holds the access encodings, requester ids and the outstanding-read record.
package regfile_sched_pkg;

   localparam logic RF_READ  = 1'b0;
   localparam logic RF_WRITE = 1'b1;

   localparam logic RD_RS1 = 1'b0;
   localparam logic RD_RS2 = 1'b1;

   localparam int REG_ZERO = 0;

   // Width of the forwarded-data field kept with an outstanding read
   localparam int RF_XLEN = 32;

   typedef struct packed {
      logic               valid;
      logic               port;
      logic               zero;
      logic               bypass;
      logic [RF_XLEN-1:0] bypass_data;
   } rd_outst_t;

   function automatic logic [1:0] port_onehot(input logic port);
      return (port == RD_RS2) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; the pointer moves to the other input
// whenever a grant is issued.
module rr_arbiter2
   import regfile_sched_pkg::*;
(
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [1:0] req,
   output logic [1:0] gnt,
   output logic       gnt_id
);

   logic ptr;

   always_comb begin
      gnt_id = ptr;
      unique case (req)
         2'b01:   gnt_id = RD_RS1;
         2'b10:   gnt_id = RD_RS2;
         default: gnt_id = ptr;
      endcase
      gnt = '0;
      if (|req) begin
         gnt = port_onehot(gnt_id);
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         ptr <= RD_RS1;
      end else if (|req) begin
         ptr <= ~gnt_id;
      end
   end

endmodule

// File: rtl/regfile_port_scheduler.sv
// Shares a single-port RegisterFile between the commit write port and two issue
// read ports. Build option: REGFILE_WR_BYPASS_EN forwards same-cycle write data.
module regfile_port_scheduler
   import regfile_sched_pkg::*;
#(
   parameter int MAX_WR_STREAK = 4,
   parameter int REG_W         = 5,
   parameter int XLEN          = 32
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   input  logic             flush_pipline,
   input  logic             wr_valid,
   input  logic [REG_W-1:0] wr_reg,
   input  logic [XLEN-1:0]  wr_data,
   output logic             wr_ready,
   input  logic [1:0]       rd_valid,
   input  logic [REG_W-1:0] rd_reg0,
   input  logic [REG_W-1:0] rd_reg1,
   output logic [1:0]       rd_ready,
   output logic [1:0]       rd_resp_valid,
   output logic [XLEN-1:0]  rd_resp_data,
   output logic             rf_have_task,
   output logic [REG_W-1:0] rf_reg_id,
   output logic             rf_rw,
   output logic [XLEN-1:0]  rf_data_in,
   input  logic [XLEN-1:0]  rf_data_out
);

   localparam int SW = $clog2(MAX_WR_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_WR_STREAK);

   logic [SW-1:0]    streak;
   rd_outst_t        outst;
   logic             held;
   logic [XLEN-1:0]  held_data;

   logic             active;
   logic [1:0]       rd_req;
   logic             read_pending;
   logic             wr_zero;
   logic             wr_grant;
   logic [1:0]       byp_match;
   logic             bypass_hit;
   logic [1:0]       arb_req;
   logic [1:0]       arb_gnt;
   logic             arb_id;
   logic             rd_grant;
   logic [REG_W-1:0] rd_sel_reg;
   logic             rd_zero;
   logic [XLEN-1:0]  resp_src;
   logic             resp_fire;

   // Writes win unless a read has already watched MAX_WR_STREAK writes go by
   always_comb begin
      active       = rdy_in && !rst_in;
      rd_req       = (active && !flush_pipline) ? rd_valid : 2'b00;
      read_pending = |rd_req;
      wr_zero      = (wr_reg == REG_W'(REG_ZERO));
      wr_grant     = active && wr_valid && (!read_pending || (streak < STREAK_MAX));
   end

`ifdef REGFILE_WR_BYPASS_EN
   always_comb begin
      byp_match = 2'b00;
      if (wr_grant && !wr_zero) begin
         byp_match[0] = rd_req[0] && (rd_reg0 == wr_reg);
         byp_match[1] = rd_req[1] && (rd_reg1 == wr_reg);
      end
   end
`else
   assign byp_match = 2'b00;
`endif

   // With a write granted, only a forwarded read may share the cycle
   assign arb_req    = wr_grant ? byp_match : rd_req;
   assign bypass_hit = |byp_match;

   rr_arbiter2 u_arb (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .req    (arb_req),
      .gnt    (arb_gnt),
      .gnt_id (arb_id)
   );

   always_comb begin
      rd_grant     = |arb_gnt;
      rd_sel_reg   = (arb_id == RD_RS2) ? rd_reg1 : rd_reg0;
      rd_zero      = (rd_sel_reg == REG_W'(REG_ZERO));
      rf_have_task = 1'b0;
      rf_rw        = RF_READ;
      rf_reg_id    = '0;
      rf_data_in   = '0;
      if (wr_grant) begin
         if (!wr_zero) begin
            rf_have_task = 1'b1;
            rf_rw        = RF_WRITE;
            rf_reg_id    = wr_reg;
            rf_data_in   = wr_data;
         end
      end else if (rd_grant && !rd_zero) begin
         rf_have_task = 1'b1;
         rf_reg_id    = rd_sel_reg;
      end
      wr_ready = wr_grant;
      rd_ready = arb_gnt;
   end

   // A response held across a pause replays the data captured when it first fell due
   always_comb begin
      if (outst.zero) begin
         resp_src = '0;
      end else if (outst.bypass) begin
         resp_src = XLEN'(outst.bypass_data);
      end else begin
         resp_src = rf_data_out;
      end
      resp_fire     = active && outst.valid && !flush_pipline;
      rd_resp_valid = resp_fire ? port_onehot(outst.port) : 2'b00;
      rd_resp_data  = '0;
      if (resp_fire) begin
         rd_resp_data = held ? held_data : resp_src;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         streak    <= '0;
         outst     <= '0;
         held      <= 1'b0;
         held_data <= '0;
      end else if (!rdy_in) begin
         if (outst.valid && !held) begin
            held      <= 1'b1;
            held_data <= resp_src;
         end
      end else begin
         held              <= 1'b0;
         outst.valid       <= rd_grant;
         outst.port        <= arb_id;
         outst.zero        <= rd_zero;
         outst.bypass      <= bypass_hit;
         outst.bypass_data <= RF_XLEN'(wr_data);
         if (flush_pipline) begin
            streak <= '0;
         end else if (wr_grant) begin
            if (bypass_hit || wr_zero) begin
               streak <= streak;
            end else if (read_pending) begin
               streak <= (streak == STREAK_MAX) ? streak : streak + SW'(1);
            end else begin
               streak <= '0;
            end
         end else if (rd_grant) begin
            streak <= '0;
         end
      end
   end

endmodule

// File: tb/tb_regfile_port_scheduler.sv
// Self-checking bench for regfile_port_scheduler: directed scenarios plus a
// randomized run against a behavioural model of the grant and response rules.
module tb_regfile_port_scheduler;

   localparam int MAX_WR_STREAK = 4;
   localparam int REG_W         = 5;
   localparam int XLEN          = 32;

   logic             clk_in = 1'b0;
   logic             rst_in;
   logic             rdy_in;
   logic             flush_pipline;
   logic             wr_valid;
   logic [REG_W-1:0] wr_reg;
   logic [XLEN-1:0]  wr_data;
   logic             wr_ready;
   logic [1:0]       rd_valid;
   logic [REG_W-1:0] rd_reg0;
   logic [REG_W-1:0] rd_reg1;
   logic [1:0]       rd_ready;
   logic [1:0]       rd_resp_valid;
   logic [XLEN-1:0]  rd_resp_data;
   logic             rf_have_task;
   logic [REG_W-1:0] rf_reg_id;
   logic             rf_rw;
   logic [XLEN-1:0]  rf_data_in;
   logic [XLEN-1:0]  rf_data_out;

   logic [XLEN-1:0]  rf_mem [32];
   int errors = 0;
   int checks = 0;

   always #5 clk_in = ~clk_in;

   regfile_port_scheduler #(
      .MAX_WR_STREAK (MAX_WR_STREAK),
      .REG_W         (REG_W),
      .XLEN          (XLEN)
   ) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .rdy_in        (rdy_in),
      .flush_pipline (flush_pipline),
      .wr_valid      (wr_valid),
      .wr_reg        (wr_reg),
      .wr_data       (wr_data),
      .wr_ready      (wr_ready),
      .rd_valid      (rd_valid),
      .rd_reg0       (rd_reg0),
      .rd_reg1       (rd_reg1),
      .rd_ready      (rd_ready),
      .rd_resp_valid (rd_resp_valid),
      .rd_resp_data  (rd_resp_data),
      .rf_have_task  (rf_have_task),
      .rf_reg_id     (rf_reg_id),
      .rf_rw         (rf_rw),
      .rf_data_in    (rf_data_in),
      .rf_data_out   (rf_data_out)
   );

   // Advances one clock and plays the RegisterFile; unread cycles get junk data
   task automatic tick();
      logic             strobe;
      logic             rw;
      logic [REG_W-1:0] id;
      logic [XLEN-1:0]  din;
      strobe = rf_have_task;
      rw     = rf_rw;
      id     = rf_reg_id;
      din    = rf_data_in;
      @(posedge clk_in);
      #1;
      if (strobe && rw) rf_mem[id] = din;
      if (strobe && !rw) rf_data_out = rf_mem[id];
      else rf_data_out = $urandom;
   endtask

   task automatic set_idle();
      rst_in        = 1'b0;
      rdy_in        = 1'b1;
      flush_pipline = 1'b0;
      wr_valid      = 1'b0;
      wr_reg        = '0;
      wr_data       = '0;
      rd_valid      = 2'b00;
      rd_reg0       = '0;
      rd_reg1       = '0;
   endtask

   task automatic test_reset();
      set_idle();
      rst_in   = 1'b1;
      wr_valid = 1'b1;
      wr_reg   = 5'd3;
      wr_data  = 32'h1;
      rd_valid = 2'b11;
      rd_reg0  = 5'd1;
      rd_reg1  = 5'd2;
      tick();
      #3;
      checks++;
      if ({wr_ready, rd_ready, rf_have_task, rd_resp_valid} !== 6'b0) begin
         errors++;
         $display("[TB] FAIL reset_ctrl: got %b expected 000000", {wr_ready, rd_ready, rf_have_task, rd_resp_valid});
      end
      checks++;
      if ({rf_reg_id, rf_rw, rf_data_in, rd_resp_data} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_data: got %h expected 0", {rf_reg_id, rf_rw, rf_data_in, rd_resp_data});
      end
      tick();
      set_idle();
      rd_valid = 2'b11;
      rd_reg0  = 5'd1;
      rd_reg1  = 5'd2;
      #3;
      checks++;
      if (rd_ready !== 2'b01) begin
         errors++;
         $display("[TB] FAIL reset_pointer: got %b expected 01", rd_ready);
      end
      tick();
      set_idle();
      rst_in = 1'b1;
      #3;
      checks++;
      if (rd_resp_valid !== 2'b00) begin
         errors++;
         $display("[TB] FAIL reset_midread: got %b expected 00", rd_resp_valid);
      end
      tick();
      set_idle();
      #3;
      checks++;
      if (rd_resp_valid !== 2'b00) begin
         errors++;
         $display("[TB] FAIL reset_discard: got %b expected 00", rd_resp_valid);
      end
      tick();
   endtask

   task automatic test_basic_read();
      rf_mem[5] = 32'h1234;
      set_idle();
      rd_valid = 2'b01;
      rd_reg0  = 5'd5;
      #3;
      checks++;
      if ({rf_have_task, rf_rw, rf_reg_id, rd_ready} !== {1'b1, 1'b0, 5'd5, 2'b01}) begin
         errors++;
         $display("[TB] FAIL basic_grant: got task=%b rw=%b id=%0d rdy=%b expected 1 0 5 01", rf_have_task, rf_rw, rf_reg_id, rd_ready);
      end
      tick();
      set_idle();
      #3;
      checks++;
      if (rd_resp_valid !== 2'b01) begin
         errors++;
         $display("[TB] FAIL basic_resp_valid: got %b expected 01", rd_resp_valid);
      end
      checks++;
      if (rd_resp_data !== 32'h1234) begin
         errors++;
         $display("[TB] FAIL basic_resp_data: got %h expected 00001234", rd_resp_data);
      end
      tick();
   endtask

   task automatic test_write_streak();
      rf_mem[6] = 32'h6666;
      set_idle();
      wr_valid = 1'b1;
      wr_reg   = 5'd3;
      wr_data  = 32'hAA;
      rd_valid = 2'b10;
      rd_reg1  = 5'd6;
      for (int c = 0; c < 6; c++) begin
         #3;
         checks++;
         if (wr_ready !== (c != 4)) begin
            errors++;
            $display("[TB] FAIL streak_wr_ready cyc=%0d: got %b expected %b", c, wr_ready, (c != 4));
         end
         checks++;
         if (rd_ready !== ((c == 4) ? 2'b10 : 2'b00)) begin
            errors++;
            $display("[TB] FAIL streak_rd_ready cyc=%0d: got %b", c, rd_ready);
         end
         if (c == 5) begin
            checks++;
            if (rd_resp_valid !== 2'b10 || rd_resp_data !== 32'h6666) begin
               errors++;
               $display("[TB] FAIL streak_resp: got %b/%h expected 10/00006666", rd_resp_valid, rd_resp_data);
            end
         end
         tick();
      end
      set_idle();
      checks++;
      if (rf_mem[3] !== 32'hAA) begin
         errors++;
         $display("[TB] FAIL streak_wr_data: got %h expected 000000aa", rf_mem[3]);
      end
      tick();
   endtask

   task automatic test_rr_alternate();
      logic [1:0] prev;
      rf_mem[1] = 32'h101;
      rf_mem[2] = 32'h202;
      set_idle();
      rd_valid = 2'b11;
      rd_reg0  = 5'd1;
      rd_reg1  = 5'd2;
      prev     = 2'b00;
      for (int c = 0; c < 4; c++) begin
         #3;
         checks++;
         if (rd_ready !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
            errors++;
            $display("[TB] FAIL rr_grant cyc=%0d: got %b", c, rd_ready);
         end
         checks++;
         if (wr_ready !== 1'b0 || rf_rw !== 1'b0 || rf_have_task !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rr_rf cyc=%0d: got wr=%b rw=%b task=%b expected 0 0 1", c, wr_ready, rf_rw, rf_have_task);
         end
         if (c > 0) begin
            checks++;
            if (rd_resp_valid !== prev || rd_resp_data !== ((prev == 2'b01) ? 32'h101 : 32'h202)) begin
               errors++;
               $display("[TB] FAIL rr_resp cyc=%0d: got %b/%h expected %b", c, rd_resp_valid, rd_resp_data, prev);
            end
         end
         prev = (c % 2 == 0) ? 2'b01 : 2'b10;
         tick();
      end
      set_idle();
      #3;
      checks++;
      if (rd_resp_valid !== 2'b10 || rd_resp_data !== 32'h202) begin
         errors++;
         $display("[TB] FAIL rr_last_resp: got %b/%h expected 10/00000202", rd_resp_valid, rd_resp_data);
      end
      tick();
   endtask

   task automatic test_flush();
      rf_mem[7] = 32'h777;
      set_idle();
      rd_valid = 2'b01;
      rd_reg0  = 5'd7;
      #3;
      checks++;
      if (rd_ready !== 2'b01) begin
         errors++;
         $display("[TB] FAIL flush_setup: got %b expected 01", rd_ready);
      end
      tick();
      flush_pipline = 1'b1;
      wr_valid      = 1'b1;
      wr_reg        = 5'd4;
      wr_data       = 32'hBEEF;
      #3;
      checks++;
      if (rd_resp_valid !== 2'b00 || rd_ready !== 2'b00) begin
         errors++;
         $display("[TB] FAIL flush_read: got resp=%b rdy=%b expected 00 00", rd_resp_valid, rd_ready);
      end
      checks++;
      if (wr_ready !== 1'b1 || rf_have_task !== 1'b1 || rf_rw !== 1'b1) begin
         errors++;
         $display("[TB] FAIL flush_write: got wr=%b task=%b rw=%b expected 1 1 1", wr_ready, rf_have_task, rf_rw);
      end
      tick();
      set_idle();
      #3;
      checks++;
      if (rd_resp_valid !== 2'b00) begin
         errors++;
         $display("[TB] FAIL flush_late_resp: got %b expected 00", rd_resp_valid);
      end
      checks++;
      if (rf_mem[4] !== 32'hBEEF) begin
         errors++;
         $display("[TB] FAIL flush_wr_data: got %h expected 0000beef", rf_mem[4]);
      end
      tick();
   endtask

   task automatic test_x0();
      set_idle();
      rd_valid = 2'b01;
      rd_reg0  = 5'd0;
      #3;
      checks++;
      if (rd_ready !== 2'b01 || rf_have_task !== 1'b0) begin
         errors++;
         $display("[TB] FAIL x0_read: got rdy=%b task=%b expected 01 0", rd_ready, rf_have_task);
      end
      tick();
      set_idle();
      wr_valid = 1'b1;
      wr_reg   = 5'd0;
      wr_data  = 32'hFF;
      #3;
      checks++;
      if (wr_ready !== 1'b1 || rf_have_task !== 1'b0) begin
         errors++;
         $display("[TB] FAIL x0_write: got wr=%b task=%b expected 1 0", wr_ready, rf_have_task);
      end
      checks++;
      if (rd_resp_valid !== 2'b01 || rd_resp_data !== 32'h0) begin
         errors++;
         $display("[TB] FAIL x0_resp: got %b/%h expected 01/00000000", rd_resp_valid, rd_resp_data);
      end
      tick();
      set_idle();
      rd_valid = 2'b11;
      rd_reg0  = 5'd1;
      rd_reg1  = 5'd2;
      #3;
      checks++;
      if (rd_ready !== 2'b10) begin
         errors++;
         $display("[TB] FAIL x0_pointer: got %b expected 10", rd_ready);
      end
      tick();
      set_idle();
      tick();
   endtask

   task automatic test_rdy_stall();
      rf_mem[8] = 32'hCAFE;
      set_idle();
      rd_valid = 2'b01;
      rd_reg0  = 5'd8;
      #3;
      checks++;
      if (rd_ready !== 2'b01) begin
         errors++;
         $display("[TB] FAIL stall_setup: got %b expected 01", rd_ready);
      end
      tick();
      rdy_in   = 1'b0;
      wr_valid = 1'b1;
      wr_reg   = 5'd10;
      rd_valid = 2'b11;
      for (int c = 0; c < 3; c++) begin
         #3;
         checks++;
         if ({rf_have_task, wr_ready, rd_ready, rd_resp_valid} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL stall_quiet cyc=%0d: got %b expected 000000", c, {rf_have_task, wr_ready, rd_ready, rd_resp_valid});
         end
         tick();
      end
      set_idle();
      #3;
      checks++;
      if (rd_resp_valid !== 2'b01 || rd_resp_data !== 32'hCAFE) begin
         errors++;
         $display("[TB] FAIL stall_resp: got %b/%h expected 01/0000cafe", rd_resp_valid, rd_resp_data);
      end
      tick();
      #3;
      checks++;
      if (rd_resp_valid !== 2'b00) begin
         errors++;
         $display("[TB] FAIL stall_once: got %b expected 00", rd_resp_valid);
      end
      tick();
   endtask

   task automatic test_bypass();
      rf_mem[9] = 32'h11;
      set_idle();
      wr_valid = 1'b1;
      wr_reg   = 5'd9;
      wr_data  = 32'h55;
      rd_valid = 2'b01;
      rd_reg0  = 5'd9;
      #3;
`ifdef REGFILE_WR_BYPASS_EN
      checks++;
      if ({wr_ready, rd_ready, rf_have_task, rf_rw} !== 5'b10111) begin
         errors++;
         $display("[TB] FAIL bypass_grant: got %b expected 10111", {wr_ready, rd_ready, rf_have_task, rf_rw});
      end
      tick();
      set_idle();
      #3;
      checks++;
      if (rf_have_task !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bypass_no_strobe: got %b expected 0", rf_have_task);
      end
`else
      checks++;
      if ({wr_ready, rd_ready} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL samereg_write_first: got %b expected 100", {wr_ready, rd_ready});
      end
      tick();
      wr_valid = 1'b0;
      #3;
      checks++;
      if (rd_ready !== 2'b01 || rf_reg_id !== 5'd9 || rf_rw !== 1'b0) begin
         errors++;
         $display("[TB] FAIL samereg_read: got rdy=%b id=%0d rw=%b expected 01 9 0", rd_ready, rf_reg_id, rf_rw);
      end
      tick();
      set_idle();
      #3;
`endif
      checks++;
      if (rd_resp_valid !== 2'b01 || rd_resp_data !== 32'h55) begin
         errors++;
         $display("[TB] FAIL samereg_resp: got %b/%h expected 01/00000055", rd_resp_valid, rd_resp_data);
      end
      tick();
   endtask

   // Reference: one grant per cycle, reads see register value as of their grant
   task automatic test_random();
      int               m_streak;
      int               m_ptr;
      bit               m_rv;
      int               m_rport;
      logic [XLEN-1:0]  m_rval;
      logic [XLEN-1:0]  m_rf [32];
      logic             rdy, fl, wv, wg, e_task, e_rw, h0, h1;
      logic [1:0]       rdv, rq, e_rd_ready, e_resp_valid;
      logic [REG_W-1:0] wr, r0, r1, greg;
      logic [XLEN-1:0]  wd;
      int               bp, gp;
      set_idle();
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      m_streak = 0;
      m_ptr    = 0;
      m_rv     = 1'b0;
      m_rport  = 0;
      m_rval   = '0;
      for (int i = 0; i < 32; i++) m_rf[i] = rf_mem[i];
      for (int cyc = 0; cyc < 600; cyc++) begin
         rdy = ($urandom_range(0, 9) != 0);
         fl  = ($urandom_range(0, 19) == 0);
         wv  = ($urandom_range(0, 1) == 1);
         wr  = REG_W'($urandom_range(0, 7));
         wd  = $urandom;
         rdv = 2'($urandom_range(0, 3));
         r0  = REG_W'($urandom_range(0, 7));
         r1  = REG_W'($urandom_range(0, 7));
         rdy_in = rdy; flush_pipline = fl; wr_valid = wv; wr_reg = wr; wr_data = wd;
         rd_valid = rdv; rd_reg0 = r0; rd_reg1 = r1;
         #3;
         rq = (rdy && !fl) ? rdv : 2'b00;
         wg = rdy && wv && (rq == 2'b00 || m_streak < MAX_WR_STREAK);
         bp = -1;
`ifdef REGFILE_WR_BYPASS_EN
         h0 = wg && (wr != 0) && rq[0] && (r0 == wr);
         h1 = wg && (wr != 0) && rq[1] && (r1 == wr);
         if (h0 && h1) bp = m_ptr;
         else if (h0) bp = 0;
         else if (h1) bp = 1;
`else
         h0 = 1'b0;
         h1 = 1'b0;
`endif
         gp = -1;
         if (wg) gp = bp;
         else if (rq == 2'b11) gp = m_ptr;
         else if (rq == 2'b01) gp = 0;
         else if (rq == 2'b10) gp = 1;
         greg         = (gp == 1) ? r1 : r0;
         e_rd_ready   = (gp < 0) ? 2'b00 : ((gp == 0) ? 2'b01 : 2'b10);
         e_task       = wg ? (wr != 0) : (gp >= 0 && greg != 0);
         e_rw         = wg && (wr != 0);
         e_resp_valid = (rdy && !fl && m_rv) ? ((m_rport == 0) ? 2'b01 : 2'b10) : 2'b00;
         checks++;
         if (wr_ready !== wg) begin
            errors++;
            $display("[TB] FAIL rnd_wr_ready cyc=%0d: got %b expected %b", cyc, wr_ready, wg);
         end
         checks++;
         if (rd_ready !== e_rd_ready) begin
            errors++;
            $display("[TB] FAIL rnd_rd_ready cyc=%0d: got %b expected %b", cyc, rd_ready, e_rd_ready);
         end
         checks++;
         if (rf_have_task !== e_task) begin
            errors++;
            $display("[TB] FAIL rnd_rf_task cyc=%0d: got %b expected %b", cyc, rf_have_task, e_task);
         end
         if (e_task) begin
            checks++;
            if (rf_rw !== e_rw || rf_reg_id !== (wg ? wr : greg)) begin
               errors++;
               $display("[TB] FAIL rnd_rf_access cyc=%0d: got rw=%b id=%0d expected %b %0d", cyc, rf_rw, rf_reg_id, e_rw, (wg ? wr : greg));
            end
            if (e_rw) begin
               checks++;
               if (rf_data_in !== wd) begin
                  errors++;
                  $display("[TB] FAIL rnd_rf_data_in cyc=%0d: got %h expected %h", cyc, rf_data_in, wd);
               end
            end
         end
         checks++;
         if (rd_resp_valid !== e_resp_valid) begin
            errors++;
            $display("[TB] FAIL rnd_resp_valid cyc=%0d: got %b expected %b", cyc, rd_resp_valid, e_resp_valid);
         end
         if (e_resp_valid != 2'b00) begin
            checks++;
            if (rd_resp_data !== m_rval) begin
               errors++;
               $display("[TB] FAIL rnd_resp_data cyc=%0d: got %h expected %h", cyc, rd_resp_data, m_rval);
            end
         end
         if (rdy) begin
            if (gp >= 0) begin
               m_rv    = 1'b1;
               m_rport = gp;
               m_rval  = (bp >= 0) ? wd : ((greg == 0) ? '0 : m_rf[greg]);
               m_ptr   = 1 - gp;
            end else begin
               m_rv = 1'b0;
            end
            if (wg && wr != 0) m_rf[wr] = wd;
            if (fl) m_streak = 0;
            else if (wg) begin
               if (bp < 0 && wr != 0) begin
                  if (rq != 2'b00) m_streak = (m_streak < MAX_WR_STREAK) ? m_streak + 1 : m_streak;
                  else m_streak = 0;
               end
            end else if (gp >= 0) m_streak = 0;
         end
         tick();
      end
      set_idle();
      tick();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
      rf_data_out = '0;
      set_idle();
      test_reset();
      test_basic_read();
      test_write_streak();
      test_rr_alternate();
      test_flush();
      test_x0();
      test_rdy_stall();
      test_bypass();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
